// File: rtl/mult16x16_pkg.sv
// Shared constants, state encoding and partial-product alignment helper
// for the sequential 16x16 radix-4 Booth multiplier.
package mult16x16_pkg;

  localparam int OP_W   = 16;
  localparam int PP_NUM = 9;
  localparam int PP_W   = 18;
  localparam int ACC_W  = 34;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-extend an 18-bit partial product to accumulator width and place it
  // at weight 4^idx (radix-4 digit position).
  function automatic logic signed [ACC_W-1:0] pp_align(
    input logic signed [PP_W-1:0]  pp,
    input logic        [CNT_W-1:0] idx
  );
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    return ext <<< {idx, 1'b0};
  endfunction

endpackage

// File: rtl/mult16x16_booth.sv
// Combinational radix-4 Booth partial-product generator for 16x16 operands.
// Each operand is extended by its signedness flag, so the nine digits times
// the 17-bit multiplicand sum to the exact product in every sign mode.
module booth_r4_16x16
  import mult16x16_pkg::*;
(
  input  logic [OP_W-1:0]             multa,
  input  logic [OP_W-1:0]             multb,
  input  logic                        multa_ns,
  input  logic                        multb_ns,
  output logic [PP_NUM-1:0][PP_W-1:0] pp
);

  logic                     a_sign;
  logic                     b_sign;
  logic signed [PP_W-1:0]   a_x1;
  logic signed [PP_W-1:0]   a_x2;
  logic        [2*PP_NUM:0] b_ext;

  assign a_sign = multa_ns & multa[OP_W-1];
  assign b_sign = multb_ns & multb[OP_W-1];
  // 17-bit multiplicand in 18 bits; 2x multiplicand still fits in 18 bits.
  assign a_x1   = {{2{a_sign}}, multa};
  assign a_x2   = {a_sign, multa, 1'b0};
  // Multiplier with an implicit 0 below bit 0 and two extension bits on top.
  assign b_ext  = {{2{b_sign}}, multb, 1'b0};

  // Recode each overlapping 3-bit group into a digit in {-2..2} times A.
  always_comb begin
    pp = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp[i] = a_x1;
        3'b011:         pp[i] = a_x2;
        3'b100:         pp[i] = -a_x2;
        3'b101, 3'b110: pp[i] = -a_x1;
        default:        pp[i] = '0;
      endcase
    end
  end

endmodule

// File: rtl/mult16x16_seq_ctrl.sv
// Sequencing controller: captures an operand pair, accumulates the nine
// Booth partial products one per cycle and holds the 32-bit product on a
// valid/ready output until it is taken.
module mult16x16_seq_ctrl
  import mult16x16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_multa,
  input  logic [OP_W-1:0]   i_multb,
  input  logic              i_multa_ns,
  input  logic              i_multb_ns,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PROD_W-1:0] o_prod,
  output logic              o_busy
);

  state_t                     state_q;
  state_t                     state_d;
  logic                       accept;
  logic                       last_pp;

  logic        [OP_W-1:0]     multa_p0;
  logic        [OP_W-1:0]     multb_p0;
  logic                       multa_ns_p0;
  logic                       multb_ns_p0;

  logic        [CNT_W-1:0]    cnt_q;
  logic signed [ACC_W-1:0]    acc_p1;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [PP_W-1:0]     pp_sel;
  logic [PP_NUM-1:0][PP_W-1:0] pp;

  logic        [PROD_W-1:0]   prod_p2;

  assign accept  = (state_q == ST_IDLE) && i_valid;
  assign last_pp = (cnt_q == CNT_W'(PP_NUM - 1));

  booth_r4_16x16 u_booth (
    .multa    (multa_p0),
    .multb    (multb_p0),
    .multa_ns (multa_ns_p0),
    .multb_ns (multb_ns_p0),
    .pp       (pp)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; handshake outputs decode the state register only.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        o_busy = 1'b1;
        if (last_pp) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: operand capture, only on an accepted handshake.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      multa_p0    <= i_multa;
      multb_p0    <= i_multb;
      multa_ns_p0 <= i_multa_ns;
      multb_ns_p0 <= i_multb_ns;
    end
  end

  // 9:1 partial-product select driven by the digit counter.
  always_comb begin
    pp_sel = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      if (cnt_q == CNT_W'(i)) pp_sel = pp[i];
    end
  end

  assign acc_sum = acc_p1 + pp_align(pp_sel, cnt_q);

  // Stage p1: accumulate one aligned partial product per CALC cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_p1 <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      acc_p1 <= '0;
      cnt_q  <= '0;
    end else if (state_q == ST_CALC) begin
      acc_p1 <= acc_sum;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Stage p2: product register, loaded with the final sum including pp[8].
  always_ff @(posedge i_clk) begin
    if (i_rst)                             prod_p2 <= '0;
    else if ((state_q == ST_CALC) && last_pp) prod_p2 <= acc_sum[PROD_W-1:0];
  end

  assign o_prod = prod_p2;

endmodule
